// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: sequencing front end and HI/LO register file for the
// 32-bit sequential multiplier in the MIPS execute stage.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   op_valid, op      request strobe and opcode (0 NOP, 1 MULT, 2 MULTU,
//                     3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 NOP)
//   rs_val, rt_val    source operands
//   stall             request not accepted this cycle (multiply outstanding)
//   rd_data, rd_valid MFHI/MFLO result and its one-cycle qualifier
//   mul_a, mul_b      33-bit extended multiplier operands
//   mul_start         multiplier start, held START_HOLD cycles
//   mul_ab, mul_busy  multiplier product and busy
//   hi, lo            architectural HI/LO registers
module mult_hilo_ctrl #(
    parameter int unsigned START_HOLD = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    output logic               stall,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic signed [32:0] mul_a,
    output logic signed [32:0] mul_b,
    output logic               mul_start,
    input  logic signed [63:0] mul_ab,
    input  logic               mul_busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPND_W = DATA_W + 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MFHI  = 3'd3,
        OP_MFLO  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ARM   = 2'd2,
        RUN   = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]          hi_q, hi_d;
    logic [DATA_W-1:0]          lo_q, lo_d;
    logic [DATA_W-1:0]          rd_data_q, rd_data_d;
    logic                       rd_valid_q, rd_valid_d;
    logic signed [OPND_W-1:0]   mul_a_q, mul_a_d;
    logic signed [OPND_W-1:0]   mul_b_q, mul_b_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
        end
    end

    // Next-state: requests are only serviced in IDLE, which serialises HI/LO hazards
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULT: begin
                            mul_a_d = {rs_val[DATA_W-1], rs_val};
                            mul_b_d = {rt_val[DATA_W-1], rt_val};
                            cnt_d   = '0;
                            state_d = START;
                        end
                        OP_MULTU: begin
                            mul_a_d = {1'b0, rs_val};
                            mul_b_d = {1'b0, rt_val};
                            cnt_d   = '0;
                            state_d = START;
                        end
                        OP_MFHI: begin
                            rd_data_d  = hi_q;
                            rd_valid_d = 1'b1;
                        end
                        OP_MFLO: begin
                            rd_data_d  = lo_q;
                            rd_valid_d = 1'b1;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            START: begin
                if (cnt_q == CNT_W'(START_HOLD - 1)) begin
                    state_d = ARM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // busy may already be high here if the multiplier raised it during START
            ARM: begin
                if (mul_busy) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!mul_busy) begin
                    hi_d    = mul_ab[63:32];
                    lo_d    = mul_ab[31:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall     = (state_q != IDLE);
    assign mul_start = (state_q == START);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: directed cases from the test plan plus a random
// op stream, compared every cycle against a behavioural model of HI/LO.
module tb_mult_hilo_ctrl;

    localparam int unsigned SH = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               op_valid = 1'b0;
    logic [2:0]         op = 3'd0;
    logic [31:0]        rs_val = 32'd0;
    logic [31:0]        rt_val = 32'd0;
    logic               stall;
    logic [31:0]        rd_data;
    logic               rd_valid;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic               mul_start;
    logic signed [63:0] mul_ab = 64'sd0;
    logic               mul_busy = 1'b0;
    logic [31:0]        hi;
    logic [31:0]        lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_hilo_ctrl #(.START_HOLD(SH)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_ab(mul_ab), .mul_busy(mul_busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: HI/LO semantics plus the multiply's occupancy window
    logic        m_pend, m_seen, m_rdv;
    int          m_k;
    logic [31:0] m_hi, m_lo, m_rdd;
    logic [32:0] m_a, m_b;
    logic [63:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_seen <= 1'b0; m_rdv <= 1'b0; m_k <= 0;
            m_hi <= '0; m_lo <= '0; m_rdd <= '0; m_a <= '0; m_b <= '0; m_prod <= '0;
        end else begin
            m_rdv <= 1'b0;
            if (!m_pend) begin
                if (op_valid) begin
                    case (op)
                        3'd1: begin
                            m_pend <= 1'b1; m_k <= 0; m_seen <= 1'b0;
                            m_a <= {rs_val[31], rs_val};
                            m_b <= {rt_val[31], rt_val};
                            m_prod <= 64'(longint'($signed(rs_val)) * longint'($signed(rt_val)));
                        end
                        3'd2: begin
                            m_pend <= 1'b1; m_k <= 0; m_seen <= 1'b0;
                            m_a <= {1'b0, rs_val};
                            m_b <= {1'b0, rt_val};
                            m_prod <= {32'd0, rs_val} * {32'd0, rt_val};
                        end
                        3'd3: begin m_rdv <= 1'b1; m_rdd <= m_hi; end
                        3'd4: begin m_rdv <= 1'b1; m_rdd <= m_lo; end
                        3'd5: m_hi <= rs_val;
                        3'd6: m_lo <= rs_val;
                        default: ;
                    endcase
                end
            end else begin
                m_k <= m_k + 1;
                // after the start window: first see busy high, then capture on its fall
                if (m_k >= int'(SH)) begin
                    if (!m_seen) begin
                        if (mul_busy) m_seen <= 1'b1;
                    end else if (!mul_busy) begin
                        m_hi   <= m_prod[63:32];
                        m_lo   <= m_prod[31:0];
                        m_pend <= 1'b0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        check("stall",     64'(stall),     64'(m_pend));
        check("mul_start", 64'(mul_start), 64'(m_pend && (m_k < int'(SH))));
        check("rd_valid",  64'(rd_valid),  64'(m_rdv));
        check("rd_data",   64'(rd_data),   64'(m_rdd));
        check("hi",        64'(hi),        64'(m_hi));
        check("lo",        64'(lo),        64'(m_lo));
        check("mul_a",     {31'd0, mul_a}, {31'd0, m_a});
        check("mul_b",     {31'd0, mul_b}, {31'd0, m_b});
    end

    // Multiplier model: busy rises after a random delay, falls with the product
    int                 force_d = -1;
    int                 extra_lat = 0;
    int                 env_d, env_l;
    logic signed [65:0] env_p;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mul_start) begin
                env_d = (force_d >= 0) ? force_d : int'($urandom_range(SH + 1, 0));
                env_l = int'(SH) + 1 + int'($urandom_range(3, 0)) + extra_lat;
                env_p = $signed(mul_a) * $signed(mul_b);
                if (env_d > 0) begin
                    repeat (env_d) @(posedge clk);
                    #1;
                end
                mul_busy = 1'b1;
                mul_ab   = {$urandom, $urandom};
                repeat (env_l) @(posedge clk);
                #1;
                mul_busy = 1'b0;
                mul_ab   = env_p[63:0];
            end
        end
    end

    // Present a request and hold it until accepted; returns at edge+1
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        while (!acc && waits < 300) begin
            @(negedge clk);
            acc = !stall;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL issue_timeout: op %0d never accepted", o);
        end
        op_valid = 1'b0; op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (stall && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            n_checks++; n_errors++;
            $display("FAIL wait_idle_timeout: stall still 1");
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(4, 0))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, wsum, cnt;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Signed small operands
        issue(3'd1, 32'd3, 32'd17, w);
        check("t1_mul_a", {31'd0, mul_a}, 64'd3);
        check("t1_mul_b", {31'd0, mul_b}, 64'd17);
        check("t1_stall", 64'(stall), 64'd1);
        wait_idle();
        check("t1_lo", 64'(lo), 64'd51);
        check("t1_hi", 64'(hi), 64'd0);
        issue(3'd4, 32'd0, 32'd0, w);
        check("t1_rd_valid", 64'(rd_valid), 64'd1);
        check("t1_rd_data", 64'(rd_data), 64'd51);
        @(posedge clk);
        #1;
        check("t1_rd_valid_drop", 64'(rd_valid), 64'd0);
        check("t1_rd_data_hold", 64'(rd_data), 64'd51);

        // Signed and unsigned extension
        issue(3'd1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, w);
        wait_idle();
        check("neg7_lo", 64'(lo), 64'd49);
        check("neg7_hi", 64'(hi), 64'd0);

        // START_HOLD window and busy raised during START, with sign extension
        force_d = 0;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, w);
        check("m1x2_mul_a", {31'd0, mul_a}, 64'h1_FFFF_FFFF);
        cnt = (mul_start) ? 1 : 0;
        for (int i = 0; i < int'(SH) + 3; i++) begin
            @(negedge clk);
            if (mul_start) cnt++;
        end
        // the +1 sample above already saw cycle T+1 at its start; negedge of T+1 counted again
        check("start_hold_cycles", 64'(cnt - 1), 64'(SH));
        wait_idle();
        force_d = -1;
        check("m1x2_hi", 64'(hi), 64'hFFFF_FFFF);
        check("m1x2_lo", 64'(lo), 64'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        check("multu_mul_a", {31'd0, mul_a}, 64'h0_FFFF_FFFF);
        wait_idle();
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);

        // Hazard: MFLO presented right behind a MULT
        issue(3'd1, 32'd5, 32'd6, w);
        issue(3'd4, 32'd0, 32'd0, w);
        check("hazard_stalled", 64'(w >= int'(SH) + 2), 64'd1);
        check("hazard_rd_valid", 64'(rd_valid), 64'd1);
        check("hazard_rd_data", 64'(rd_data), 64'd30);

        // Move ops back to back
        wsum = 0;
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, w); wsum += w;
        issue(3'd6, 32'h1234_5678, 32'd0, w); wsum += w;
        issue(3'd3, 32'd0, 32'd0, w); wsum += w;
        check("mv_mfhi_valid", 64'(rd_valid), 64'd1);
        check("mv_mfhi_data", 64'(rd_data), 64'hDEAD_BEEF);
        issue(3'd4, 32'd0, 32'd0, w); wsum += w;
        check("mv_mflo_valid", 64'(rd_valid), 64'd1);
        check("mv_mflo_data", 64'(rd_data), 64'h1234_5678);
        check("mv_no_stall", 64'(wsum), 64'd0);

        // Reset in the middle of a multiply
        extra_lat = 8;
        issue(3'd1, 32'd1234, 32'd5678, w);
        cnt = 0;
        @(negedge clk);
        while (!(mul_busy && !mul_start) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        check("rst_mid_busy", 64'(mul_busy && stall), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_start", 64'(mul_start), 64'd0);
        check("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_mid_rd_data", 64'(rd_data), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_mul_a", {31'd0, mul_a}, 64'd0);
        check("rst_mid_mul_b", {31'd0, mul_b}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_stall", 64'(stall), 64'd0);
        cnt = 0;
        while (mul_busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_after_fall_hi", 64'(hi), 64'd0);
        check("rst_after_fall_lo", 64'(lo), 64'd0);
        extra_lat = 0;

        // Random op stream
        for (int i = 0; i < 200; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(7, 0));
            issue(o, pick_val(), pick_val(), w);
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
